// File: rtl/jtag_tap_sampled.sv
// JTAG TAP responder that oversamples the JTAG pins on the system clock.
// Provides IR, IDCODE, BYPASS and one user data register with update strobe.
module jtag_tap_sampled #(
    parameter int                     IR_WIDTH = 5,
    parameter logic [31:0]            IDCODE   = 32'h10E31913,
    parameter logic [IR_WIDTH-1:0]    USER_IR  = 5'h11,
    parameter int                     DR_WIDTH = 41
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                jtag_TCK,
    input  logic                jtag_TMS,
    input  logic                jtag_TDI,
    input  logic                jtag_TRSTn,
    output logic                jtag_TDO_data,
    output logic                jtag_TDO_driven,
    input  logic [DR_WIDTH-1:0] capture_data,
    output logic                update_valid,
    output logic [DR_WIDTH-1:0] update_data,
    output logic [IR_WIDTH-1:0] ir_value,
    output logic [3:0]          tap_state
);

    localparam int DRW = (DR_WIDTH > 32) ? DR_WIDTH : 32;
    localparam int AW  = $clog2(DRW);
    localparam logic [IR_WIDTH-1:0] IR_IDCODE = IR_WIDTH'(1);

    typedef enum logic [3:0] {
        TLR    = 4'hF, RTI    = 4'hC,
        SEL_DR = 4'h7, CAP_DR = 4'h6, SH_DR  = 4'h2, EX1_DR = 4'h1,
        PAU_DR = 4'h3, EX2_DR = 4'h0, UPD_DR = 4'h5,
        SEL_IR = 4'h4, CAP_IR = 4'hE, SH_IR  = 4'hA, EX1_IR = 4'h9,
        PAU_IR = 4'hB, EX2_IR = 4'h8, UPD_IR = 4'hD
    } state_e;

    logic [1:0]          tck_sync_q, tms_sync_q, tdi_sync_q, trst_sync_q;
    logic                tck_prev_q;
    state_e              state_q, state_d, state_nx;
    logic [IR_WIDTH-1:0] ir_shift_q, ir_shift_d;
    logic [IR_WIDTH-1:0] ir_q, ir_d;
    logic [DRW-1:0]      dr_q, dr_d;
    logic                tdo_q, tdo_d;
    logic                drv_q, drv_d;
    logic                uv_q, uv_d;
    logic [DR_WIDTH-1:0] ud_q, ud_d;

    logic                tck_s, tms_s, tdi_s, trst_n;
    logic                tck_rise, tck_fall;
    logic [AW-1:0]       dr_msb;

    assign tck_s    = tck_sync_q[1];
    assign tms_s    = tms_sync_q[1];
    assign tdi_s    = tdi_sync_q[1];
    assign trst_n   = trst_sync_q[1];
    assign tck_rise = tck_s & ~tck_prev_q;
    assign tck_fall = ~tck_s & tck_prev_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            tck_sync_q  <= '0;
            tms_sync_q  <= '0;
            tdi_sync_q  <= '0;
            trst_sync_q <= '0;
            tck_prev_q  <= 1'b0;
            state_q     <= TLR;
            ir_shift_q  <= '0;
            ir_q        <= IR_IDCODE;
            dr_q        <= '0;
            tdo_q       <= 1'b0;
            drv_q       <= 1'b0;
            uv_q        <= 1'b0;
            ud_q        <= '0;
        end else begin
            tck_sync_q  <= {tck_sync_q[0], jtag_TCK};
            tms_sync_q  <= {tms_sync_q[0], jtag_TMS};
            tdi_sync_q  <= {tdi_sync_q[0], jtag_TDI};
            trst_sync_q <= {trst_sync_q[0], jtag_TRSTn};
            tck_prev_q  <= tck_s;
            state_q     <= state_d;
            ir_shift_q  <= ir_shift_d;
            ir_q        <= ir_d;
            dr_q        <= dr_d;
            tdo_q       <= tdo_d;
            drv_q       <= drv_d;
            uv_q        <= uv_d;
            ud_q        <= ud_d;
        end
    end

    always_comb begin
        state_nx = TLR;
        unique case (state_q)
            TLR:     state_nx = tms_s ? TLR    : RTI;
            RTI:     state_nx = tms_s ? SEL_DR : RTI;
            SEL_DR:  state_nx = tms_s ? SEL_IR : CAP_DR;
            CAP_DR:  state_nx = tms_s ? EX1_DR : SH_DR;
            SH_DR:   state_nx = tms_s ? EX1_DR : SH_DR;
            EX1_DR:  state_nx = tms_s ? UPD_DR : PAU_DR;
            PAU_DR:  state_nx = tms_s ? EX2_DR : PAU_DR;
            EX2_DR:  state_nx = tms_s ? UPD_DR : SH_DR;
            UPD_DR:  state_nx = tms_s ? SEL_DR : RTI;
            SEL_IR:  state_nx = tms_s ? TLR    : CAP_IR;
            CAP_IR:  state_nx = tms_s ? EX1_IR : SH_IR;
            SH_IR:   state_nx = tms_s ? EX1_IR : SH_IR;
            EX1_IR:  state_nx = tms_s ? UPD_IR : PAU_IR;
            PAU_IR:  state_nx = tms_s ? EX2_IR : PAU_IR;
            EX2_IR:  state_nx = tms_s ? UPD_IR : SH_IR;
            UPD_IR:  state_nx = tms_s ? SEL_DR : RTI;
            default: state_nx = TLR;
        endcase
    end

    // Selected DR length is implied by the instruction; unknown codes are BYPASS.
    always_comb begin
        if (ir_q == IR_IDCODE)    dr_msb = AW'(31);
        else if (ir_q == USER_IR) dr_msb = AW'(DR_WIDTH - 1);
        else                      dr_msb = '0;
    end

    always_comb begin
        state_d    = state_q;
        ir_shift_d = ir_shift_q;
        ir_d       = ir_q;
        dr_d       = dr_q;
        tdo_d      = tdo_q;
        drv_d      = drv_q;
        uv_d       = 1'b0;
        ud_d       = ud_q;
        if (!trst_n) begin
            state_d = TLR;
            ir_d    = IR_IDCODE;
            tdo_d   = 1'b0;
            drv_d   = 1'b0;
        end else begin
            if (tck_rise) begin
                state_d = state_nx;
                if (state_q == CAP_IR) begin
                    ir_shift_d = IR_WIDTH'(2'b01);
                end else if (state_q == SH_IR) begin
                    ir_shift_d = {tdi_s, ir_shift_q[IR_WIDTH-1:1]};
                end else if (state_q == CAP_DR) begin
                    if (ir_q == IR_IDCODE)    dr_d = DRW'(IDCODE);
                    else if (ir_q == USER_IR) dr_d = DRW'(capture_data);
                    else                      dr_d = '0;
                end else if (state_q == SH_DR) begin
                    dr_d         = dr_q >> 1;
                    dr_d[dr_msb] = tdi_s;
                end
            end
            if (tck_fall) begin
                drv_d = (state_q == SH_DR) || (state_q == SH_IR);
                tdo_d = 1'b0;
                if (state_q == SH_IR) tdo_d = ir_shift_q[0];
                if (state_q == SH_DR) tdo_d = dr_q[0];
                if (state_q == UPD_IR) ir_d = ir_shift_q;
                if (state_q == UPD_DR && ir_q == USER_IR) begin
                    ud_d = dr_q[DR_WIDTH-1:0];
                    uv_d = 1'b1;
                end
            end
            if (state_q == TLR) ir_d = IR_IDCODE;
        end
    end

    assign jtag_TDO_data   = tdo_q;
    assign jtag_TDO_driven = drv_q;
    assign update_valid    = uv_q;
    assign update_data     = ud_q;
    assign ir_value        = ir_q;
    assign tap_state       = state_q;

endmodule
